mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waiting on mem_ready before abort.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: fetch request and word address, held stable until if_done.
REQ-006 SHALL have ports if_done out 1, if_rdata out 32: one-cycle completion pulse and instruction word.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32: MEM-stage lw/sw request, held stable until d_done.
REQ-008 SHALL have ports d_done out 1, d_rdata out 32: one-cycle completion pulse and load data.
REQ-009 SHALL have port flush  in  1  pipeline flush; discards in-flight fetch result.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ready in 1: unified single-port memory.
REQ-011 SHALL have ports stall_if out 1, stall_mem out 1: combinational hold requests to pipeline.
REQ-012 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, BUSY_I, BUSY_D, DRAIN, RESP.
REQ-014 IDLE: d_req wins -> BUSY_D, unless if_req pending and streak == MAX_D_STREAK, then BUSY_I; only if_req -> BUSY_I; none -> stay.
REQ-015 On grant SHALL latch address/we/wdata into registers; mem_* driven from registers only.
REQ-016 mem_req SHALL be high in BUSY_I, BUSY_D, DRAIN; mem_we high only in BUSY_D with latched d_we.
REQ-017 BUSY_x with mem_ready -> RESP, capturing mem_rdata; RESP pulses matching done for exactly one cycle, then IDLE.
REQ-018 Minimum latency: req in IDLE cycle N, mem_ready in N+1 -> done in N+2; one access per three cycles max.
REQ-019 Streak counter SHALL increment on each data grant while if_req high, clear on fetch grant or when if_req low, saturate at MAX_D_STREAK.
REQ-020 flush while BUSY_I without mem_ready -> DRAIN; DRAIN waits mem_ready then IDLE with no if_done.
REQ-021 flush with mem_ready same cycle in BUSY_I -> IDLE, no if_done; flush in RESP for fetch suppresses if_done.
REQ-022 flush SHALL NOT affect BUSY_D or DRAIN.
REQ-023 Watchdog counts cycles in BUSY_x/DRAIN; at TIMEOUT without mem_ready -> RESP (from DRAIN -> IDLE), rdata 0, err set.
REQ-024 stall_if = if_req & ~if_done; stall_mem = d_req & ~d_done.
REQ-025 Requests arriving outside IDLE SHALL wait; no request is dropped.
REQ-026 d_we=1 SHALL return d_rdata 0.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, clear streak, watchdog, err, latched registers; all outputs 0.
REQ-028 Reset mid-access SHALL abandon it with no done pulse; the memory sees mem_req drop immediately.

Structure
REQ-029 State enum, TIMEOUT and MAX_D_STREAK defaults SHALL live in shared package rv_pipe_pkg.
REQ-030 Watchdog counter SHALL be sub-module mem_arb_watchdog (start, clear, expire).

Verification
REQ-031 if_req addr 0x10, mem_ready 1 cycle after mem_req, rdata 0x00500093 -> if_done 2 cycles after request, if_rdata 0x00500093.
REQ-032 if_req and d_req (sw 0x20, data 7) same cycle -> mem_we=1 addr 0x20 first, fetch served after d_done.
REQ-033 d_req held with if_req for 5 accesses -> 4 data grants, then fetch granted, streak cleared.
REQ-034 flush in BUSY_I before mem_ready -> DRAIN, no if_done, next if_req addr 0x40 served normally.
REQ-035 mem_ready never asserted -> at cycle 16 d_done pulses, d_rdata 0, err=1 held until reset.
REQ-036 reset low during BUSY_D -> all outputs 0 immediately, no d_done after release.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and defaults for the unified memory port arbiter.
package rv_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT      = 16;
    localparam int DEFAULT_MAX_D_STREAK = 4;

    // True in every state that keeps an access outstanding on the memory.
    function automatic logic is_busy(input arb_state_e s);
        return (s == BUSY_I) || (s == BUSY_D) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle watchdog: armed on grant, expires on the TIMEOUT-th cycle
// spent waiting for mem_ready, disarmed when the access ends.
module mem_arb_watchdog
    import rv_pipe_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic          active_q;
    logic [CW-1:0] count_q;

    // Arm on start, count each waiting cycle, saturate at TIMEOUT.
    // NOTE: async active-low reset lives in the sensitivity list; every state bit gets a reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (clear) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            count_q  <= '0;
        end else if (active_q && (count_q != CW'(TIMEOUT))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = active_q && (count_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// with data priority bounded by a streak limit, flush draining and a watchdog.
module mem_port_arbiter
    import rv_pipe_pkg::*;
#(
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_e    state_q, state_d;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          we_q, fetch_q;
    logic [SW-1:0] streak_q;
    logic          grant_i, grant_d, capture, timeout_hit;
    logic          wd_clear, wd_expire;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (grant_i | grant_d),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    // Next-state, grant and completion decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && (streak_q == SW'(MAX_D_STREAK)))) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (if_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    capture = 1'b1;
                    state_d = flush ? IDLE : RESP;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = flush ? IDLE : RESP;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            DRAIN: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wd_clear = is_busy(state_q) && !is_busy(state_d);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the granted request, capture read data, track the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            rdata_q <= '0;
            err     <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                addr_q  <= grant_d ? d_addr : if_addr;
                wdata_q <= grant_d ? d_wdata : '0;
                we_q    <= grant_d && d_we;
                fetch_q <= grant_i;
            end
            // Stores return zero; a timed-out access returns zero.
            if (capture)          rdata_q <= we_q ? '0 : mem_rdata;
            else if (timeout_hit) rdata_q <= '0;
            if (timeout_hit)      err <= 1'b1;
        end
    end

    // Count data grants made while a fetch is waiting, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     streak_q <= '0;
        else if (!if_req || grant_i)                    streak_q <= '0;
        else if (grant_d && (streak_q != SW'(MAX_D_STREAK))) streak_q <= streak_q + 1'b1;
    end

    assign mem_req   = is_busy(state_q);
    assign mem_we    = (state_q == BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flush arriving in the response cycle cancels the fetch completion.
    assign if_done   = (state_q == RESP) && fetch_q && !flush;
    assign d_done    = (state_q == RESP) && !fetch_q;
    assign if_rdata  = fetch_q ? rdata_q : '0;
    assign d_rdata   = fetch_q ? '0 : rdata_q;

    // Hold requests are gated by reset so every output reads zero while it is asserted.
    assign stall_if  = reset && if_req && !if_done;
    assign stall_mem = reset && d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, flush, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_done, d_done, mem_req, mem_we, stall_if, stall_mem, err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int          tests_run    = 0;
    int          tests_failed = 0;

    // Memory responder settings: mem_lat = waiting cycles before ready (-1: never).
    int          mem_lat  = 0;
    logic [31:0] mem_data = '0;
    int          wait_cnt = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory responder: raises mem_ready after mem_lat waiting cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (mem_lat >= 0) && (wait_cnt == mem_lat);
                mem_rdata = mem_data;
                wait_cnt++;
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Advance one cycle; sample and drive just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; flush = 1'b0;
        if_addr = 32'h4; d_addr = 32'h8; d_wdata = '0;
        repeat (3) tick();
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests_run++;
        if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin
            tests_failed++; $display("FAIL reset_stall: got if=%b mem=%b want 0/0", stall_if, stall_mem);
        end
        tests_run++;
        if ({if_done, d_done, err, mem_we} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got done=%b%b err=%b we=%b addr=%h wdata=%h want all 0",
                     if_done, d_done, err, mem_we, mem_addr, mem_wdata);
        end
        if_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;
        tick();
        tests_run++;
        if (mem_req !== 1'b0 || stall_if !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idle: got mem_req=%b stall_if=%b want 0/0", mem_req, stall_if);
        end
    endtask

    // Single fetch with minimum latency: done two cycles after the request.
    task automatic test_fetch(input logic [31:0] addr, input logic [31:0] word);
        mem_lat = 0; mem_data = word;
        if_req = 1'b1; if_addr = addr;
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr || if_done !== 1'b0 || stall_if !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_busy: got req=%b we=%b addr=%h done=%b stall=%b want 1/0/%h/0/1",
                     mem_req, mem_we, mem_addr, if_done, stall_if, addr);
        end
        tick();
        tests_run++;
        if (if_done !== 1'b1 || if_rdata !== word || stall_if !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_done: got done=%b rdata=%h stall=%b want 1/%h/0", if_done, if_rdata, stall_if, word);
        end
        if_req = 1'b0;
        tick();
        tests_run++;
        if (if_done !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_after: got done=%b req=%b want 0/0", if_done, mem_req);
        end
    endtask

    // Simultaneous fetch and store: store goes first, fetch follows.
    task automatic test_priority();
        mem_lat = 0; mem_data = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h7;
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h7) begin
            tests_failed++;
            $display("FAIL prio_store_first: got req=%b we=%b addr=%h wdata=%h want 1/1/00000020/00000007",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (d_done !== 1'b1 || d_rdata !== 32'h0 || if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_store_done: got d_done=%b d_rdata=%h if_done=%b want 1/0/0", d_done, d_rdata, if_done);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44) begin
            tests_failed++;
            $display("FAIL prio_fetch_next: got req=%b we=%b addr=%h want 1/0/00000044", mem_req, mem_we, mem_addr);
        end
        tick();
        tests_run++;
        if (if_done !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL prio_fetch_done: got done=%b rdata=%h want 1/deadbeef", if_done, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    // Continuous loads with a waiting fetch: four loads, then the fetch, then loads again.
    task automatic test_streak();
        int order[$];
        int exp_order[6] = '{0, 0, 0, 0, 1, 0};
        bit seen;
        mem_lat = 1; mem_data = 32'h1111;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int c = 0; c < 80 && order.size() < 6; c++) begin
            tick();
            if (if_done) begin order.push_back(1); if_addr = 32'h84; end
            if (d_done) begin
                order.push_back(0);
                if (order.size() == 6) d_req = 1'b0;
            end
        end
        tests_run++;
        if (order.size() != 6) begin
            tests_failed++; $display("FAIL streak_count: got %0d completions want 6", order.size());
        end
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            tests_run++;
            if (order[i] != exp_order[i]) begin
                tests_failed++;
                $display("FAIL streak_order[%0d]: got %0d want %0d (1=fetch 0=data)", i, order[i], exp_order[i]);
            end
        end
        d_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (if_done) seen = 1'b1;
        end
        if_req = 1'b0;
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL streak_last_fetch: got no if_done want if_done"); end
        tick();
    endtask

    // Flush while the fetch waits: drain silently, then a new fetch works.
    task automatic test_flush_drain();
        bit any_done;
        bit idle_seen;
        mem_lat = 3; mem_data = 32'hBAD0BAD0;
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        tests_run++;
        if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL drain_holds_req: got %b want 1", mem_req); end
        any_done = 1'b0; idle_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_done) any_done = 1'b1;
            if (!mem_req) idle_seen = 1'b1;
        end
        tests_run++;
        if (any_done || !idle_seen) begin
            tests_failed++; $display("FAIL drain_quiet: got if_done_seen=%b idle_seen=%b want 0/1", any_done, idle_seen);
        end
        test_fetch(32'h40, 32'h00A00113);
    endtask

    // Flush coinciding with mem_ready, and flush during the response cycle.
    task automatic test_flush_resp();
        mem_lat = 0; mem_data = 32'h12345678;
        if_req = 1'b1; if_addr = 32'h50;
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0 || if_done !== 1'b0) begin
            tests_failed++; $display("FAIL flush_ready_idle: got req=%b done=%b want 0/0", mem_req, if_done);
        end
        if_req = 1'b1; if_addr = 32'h54;
        tick();
        tick();
        flush = 1'b1;
        #1;
        tests_run++;
        if (if_done !== 1'b0) begin tests_failed++; $display("FAIL flush_resp_suppress: got %b want 0", if_done); end
        flush = 1'b0; if_req = 1'b0;
        tick();
    endtask

    // Memory never answers: the load aborts after TIMEOUT waiting cycles.
    task automatic test_timeout();
        int busy;
        bit seen;
        mem_lat = -1; mem_data = 32'hFFFF0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        busy = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (mem_req) busy++;
            if (d_done) seen = 1'b1;
        end
        tests_run++;
        if (!seen || busy != 16) begin
            tests_failed++; $display("FAIL timeout_cycles: got done=%b wait=%0d want 1/16", seen, busy);
        end
        tests_run++;
        if (d_rdata !== 32'h0 || err !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_result: got rdata=%h err=%b want 0/1", d_rdata, err);
        end
        d_req = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (err !== 1'b1 || mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_sticky: got err=%b req=%b want 1/0", err, mem_req);
        end
    endtask

    // Reset during a store: everything drops at once, no completion afterwards.
    task automatic test_reset_mid();
        bit any_done;
        mem_lat = -1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55;
        tick();
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            tests_failed++; $display("FAIL rmid_busy: got req=%b we=%b want 1/1", mem_req, mem_we);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_we, d_done, err, stall_mem} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rmid_outputs: got req=%b we=%b done=%b err=%b stall=%b addr=%h wdata=%h want all 0",
                     mem_req, mem_we, d_done, err, stall_mem, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        reset = 1'b1; mem_lat = 0;
        any_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (d_done || mem_req) any_done = 1'b1;
        end
        tests_run++;
        if (any_done) begin tests_failed++; $display("FAIL rmid_no_done: got activity after reset want none"); end
    endtask

    initial begin
        test_reset();
        test_fetch(32'h10, 32'h00500093);
        test_priority();
        test_streak();
        test_flush_drain();
        test_flush_resp();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
